// File: rtl/a2d_pkg.sv
// Shared types and command-word constants for the A2D scanner.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, CMD, GAP, DATA, ACC, WR} state_t;

  localparam int         CMD_CH_OFS = 11;
  localparam logic [1:0] CMD_PFX    = 2'b00;

  // Channel-select command word sent to the converter.
  function automatic logic [15:0] mk_cmd(input logic [2:0] ch);
    return {CMD_PFX, ch, {CMD_CH_OFS{1'b0}}};
  endfunction

endpackage

// File: rtl/a2d_scan_if.sv
// Host-side control/result bus of the A2D scanner.
interface a2d_scan_if #(
  parameter int NUM_CHNNL = 8,
  parameter int RES_W     = 12
);
  logic                 strt_cnv;
  logic [2:0]           chnnl;
  logic                 scan_en;
  logic [2:0]           rd_chnnl;
  logic [RES_W-1:0]     rd_res;
  logic [NUM_CHNNL-1:0] vld;
  logic                 busy;
  logic                 cnv_cmplt;
  logic [2:0]           cmplt_chnnl;

  modport master (
    output strt_cnv, chnnl, scan_en, rd_chnnl,
    input  rd_res, vld, busy, cnv_cmplt, cmplt_chnnl
  );

  modport slave (
    input  strt_cnv, chnnl, scan_en, rd_chnnl,
    output rd_res, vld, busy, cnv_cmplt, cmplt_chnnl
  );
endinterface

// File: rtl/SPI_mnrch.sv
// 16-bit SPI master, SCLK idles high, MISO sampled on SCLK rise, MOSI shifted on fall.
module SPI_mnrch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] resp,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  logic        r_actv;
  logic [4:0]  r_div;
  logic [4:0]  r_rise;
  logic [15:0] r_shft;
  logic        r_smpl;
  logic        r_done;
  logic        r_ss_n;
  logic        w_rise;
  logic        w_fall;

  assign w_rise = r_actv && (r_div == 5'b01111);
  assign w_fall = r_actv && (r_div == 5'b11111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_actv <= 1'b0;
      r_div  <= 5'd0;
      r_rise <= 5'd0;
      r_shft <= 16'd0;
      r_smpl <= 1'b0;
      r_done <= 1'b0;
      r_ss_n <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (!r_actv) begin
        if (snd) begin
          // Start with SCLK high for a half period so the first fall is a clean edge.
          r_actv <= 1'b1;
          r_ss_n <= 1'b0;
          r_div  <= 5'b10000;
          r_rise <= 5'd0;
          r_shft <= cmd;
        end
      end else begin
        r_div <= r_div + 5'd1;
        if (w_rise) begin
          r_smpl <= MISO;
          r_rise <= r_rise + 5'd1;
        end
        if (w_fall) begin
          if (r_rise != 5'd0) r_shft <= {r_shft[14:0], r_smpl};
          if (r_rise == 5'd16) begin
            r_actv <= 1'b0;
            r_ss_n <= 1'b1;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign SCLK = r_actv ? r_div[4] : 1'b1;
  assign MOSI = r_shft[15];
  assign resp = r_shft;
  assign done = r_done;
  assign SS_n = r_ss_n;

endmodule

// File: rtl/a2d_scan.sv
// A2D channel scanner: single or round-robin conversions, optional averaging, result bank.
module a2d_scan
  import a2d_pkg::*;
#(
  parameter int NUM_CHNNL = 8,
  parameter int RES_W     = 12,
  parameter int AVG_LOG2  = 0
) (
  input  logic     clk,
  input  logic     rst,
  a2d_scan_if.slave bus,
  output logic     a2d_SS_n,
  output logic     SCLK,
  output logic     MOSI,
  input  logic     MISO
);

  localparam int             ACC_W   = 12 + AVG_LOG2;
  localparam int             SCW     = AVG_LOG2 + 1;
  localparam logic [SCW-1:0] NSMP    = SCW'(1 << AVG_LOG2);
  localparam logic [3:0]     NCH     = 4'(NUM_CHNNL);
  localparam logic [2:0]     LAST_CH = 3'(NUM_CHNNL - 1);

  state_t               r_state, w_nxt;
  logic [2:0]           r_cur_ch, r_scan_ptr, w_nxt_ptr;
  logic                 r_scan;
  logic [SCW-1:0]       r_smp_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic [RES_W-1:0]     r_bank [NUM_CHNNL];
  logic [NUM_CHNNL-1:0] r_vld;

  logic                 w_snd, w_done;
  logic [15:0]          w_resp;
  logic                 w_strt_ok, w_start, w_start_scan;
  logic [2:0]           w_start_ch, w_cmd_ch;
  logic                 w_acc_en, w_wr;
  logic [RES_W-1:0]     w_wr_val, w_rd;
  logic [NUM_CHNNL-1:0] w_ch_oh;
  logic                 w_unused_resp;

  assign w_strt_ok = bus.strt_cnv && ({1'b0, bus.chnnl} < NCH);
  assign w_nxt_ptr = (r_scan_ptr == LAST_CH) ? 3'd0 : r_scan_ptr + 3'd1;
  // Shifting out the average and the dropped LSBs in one step keeps the top RES_W bits.
  assign w_wr_val  = RES_W'(r_acc >> (AVG_LOG2 + 12 - RES_W));
  assign w_ch_oh   = NUM_CHNNL'(1) << r_cur_ch;
  assign w_unused_resp = ^w_resp[15:12];

  always_comb begin
    w_nxt        = r_state;
    w_snd        = 1'b0;
    w_start      = 1'b0;
    w_start_scan = 1'b0;
    w_start_ch   = r_cur_ch;
    w_acc_en     = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_strt_ok) begin
          w_start    = 1'b1;
          w_start_ch = bus.chnnl;
        end else if (bus.scan_en) begin
          w_start      = 1'b1;
          w_start_scan = 1'b1;
          w_start_ch   = r_scan_ptr;
        end
        if (w_start) begin
          w_snd = 1'b1;
          w_nxt = CMD;
        end
      end
      CMD:  if (w_done) w_nxt = GAP;
      GAP: begin
        w_snd = 1'b1;
        w_nxt = DATA;
      end
      DATA: if (w_done) begin
        w_acc_en = 1'b1;
        w_nxt    = ACC;
      end
      ACC: begin
        if (r_smp_cnt != NSMP) begin
          w_snd = 1'b1;
          w_nxt = CMD;
        end else begin
          w_nxt = WR;
        end
      end
      WR: begin
        w_wr = 1'b1;
        if (r_scan && bus.scan_en) begin
          w_start      = 1'b1;
          w_start_scan = 1'b1;
          w_start_ch   = w_nxt_ptr;
          w_snd        = 1'b1;
          w_nxt        = CMD;
        end else begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur_ch   <= 3'd0;
      r_scan_ptr <= 3'd0;
      r_scan     <= 1'b0;
      r_smp_cnt  <= '0;
      r_acc      <= '0;
      r_vld      <= '0;
      for (int i = 0; i < NUM_CHNNL; i++) r_bank[i] <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_cur_ch  <= w_start_ch;
        r_scan    <= w_start_scan;
        r_smp_cnt <= '0;
        r_acc     <= '0;
      end
      if (w_acc_en) begin
        r_acc     <= r_acc + ACC_W'(w_resp[11:0]);
        r_smp_cnt <= r_smp_cnt + SCW'(1);
      end
      if (w_wr) begin
        r_vld <= r_vld | w_ch_oh;
        for (int i = 0; i < NUM_CHNNL; i++)
          if (r_cur_ch == 3'(i)) r_bank[i] <= w_wr_val;
        if (r_scan) r_scan_ptr <= w_nxt_ptr;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CHNNL; i++)
      if (bus.rd_chnnl == 3'(i)) w_rd = r_bank[i];
  end

  // The SPI engine latches cmd on snd, so a fresh start must present the new channel.
  assign w_cmd_ch = w_start ? w_start_ch : r_cur_ch;

  SPI_mnrch u_spi (
    .clk  (clk),
    .rst_n(~rst),
    .snd  (w_snd),
    .cmd  (mk_cmd(w_cmd_ch)),
    .done (w_done),
    .resp (w_resp),
    .SS_n (a2d_SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  assign bus.rd_res      = w_rd;
  assign bus.vld         = r_vld;
  assign bus.busy        = (r_state != IDLE);
  assign bus.cnv_cmplt   = (r_state == WR);
  assign bus.cmplt_chnnl = r_cur_ch;

endmodule

// File: tb/tb_a2d_scan.sv
// Directed bench: three scanner configurations, each driven against a behavioural A2D slave.
module tb_a2d_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire  [2:0] ss_n, sclk, mosi;
  logic [11:0] tab [3][4];
  int n_chk = 0;
  int n_err = 0;

  a2d_scan_if #(.NUM_CHNNL(8), .RES_W(12)) a_if ();
  a2d_scan_if #(.NUM_CHNNL(4), .RES_W(12)) b_if ();
  a2d_scan_if #(.NUM_CHNNL(3), .RES_W(8))  c_if ();

  // Mode-3 slave: next bit on each SCLK fall, MOSI captured on each rise.
  for (genvar g = 0; g < 3; g++) begin : slv
    logic [15:0] sh   = 16'd0;
    logic [15:0] rx   = 16'd0;
    logic [15:0] lcmd = 16'd0;
    logic        miso = 1'b0;
    int          frm  = 0;
    always @(negedge ss_n[g]) begin
      sh  = {4'h0, tab[g][(frm >> 1) & 3]};
      frm = frm + 1;
    end
    always @(negedge sclk[g]) if (!ss_n[g]) begin
      miso = sh[15];
      sh   = {sh[14:0], 1'b0};
    end
    always @(posedge sclk[g]) if (!ss_n[g]) rx = {rx[14:0], mosi[g]};
    always @(posedge ss_n[g]) lcmd = rx;
  end

  a2d_scan #(.NUM_CHNNL(8), .RES_W(12), .AVG_LOG2(0)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if),
    .a2d_SS_n(ss_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(slv[0].miso));
  a2d_scan #(.NUM_CHNNL(4), .RES_W(12), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if),
    .a2d_SS_n(ss_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(slv[1].miso));
  a2d_scan #(.NUM_CHNNL(3), .RES_W(8), .AVG_LOG2(0)) dut_c (
    .clk(clk), .rst(rst), .bus(c_if),
    .a2d_SS_n(ss_n[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .MISO(slv[2].miso));

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (ss_n !== 3'b111) begin n_err++; $display("FAIL rst_ss_n got %b exp 111", ss_n); end
    n_chk++; if ({a_if.busy, b_if.busy, c_if.busy} !== 3'b000) begin n_err++; $display("FAIL rst_busy got %b exp 000", {a_if.busy, b_if.busy, c_if.busy}); end
    n_chk++; if (a_if.vld !== 8'h00) begin n_err++; $display("FAIL rst_vld got %h exp 00", a_if.vld); end
    n_chk++; if ({a_if.cnv_cmplt, c_if.cnv_cmplt} !== 2'b00) begin n_err++; $display("FAIL rst_cmplt got %b exp 00", {a_if.cnv_cmplt, c_if.cnv_cmplt}); end
    n_chk++; if (a_if.rd_res !== 12'h000) begin n_err++; $display("FAIL rst_rd_res got %h exp 000", a_if.rd_res); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t, f0;
    for (int i = 0; i < 4; i++) tab[0][i] = 12'hA5C;
    f0 = slv[0].frm;
    a_if.rd_chnnl = 3'd5;
    a_if.chnnl = 3'd5; a_if.strt_cnv = 1'b1;
    @(negedge clk);
    a_if.strt_cnv = 1'b0;
    n_chk++; if (a_if.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", a_if.busy); end
    t = 0;
    while (!a_if.cnv_cmplt && t < 3000) begin @(negedge clk); t++; end
    n_chk++; if (a_if.cnv_cmplt !== 1'b1) begin n_err++; $display("FAIL single_timeout got %b exp 1", a_if.cnv_cmplt); end
    n_chk++; if (a_if.cmplt_chnnl !== 3'd5) begin n_err++; $display("FAIL single_cmplt_ch got %0d exp 5", a_if.cmplt_chnnl); end
    n_chk++; if (a_if.rd_res !== 12'h000) begin n_err++; $display("FAIL single_rd_during_wr got %h exp 000", a_if.rd_res); end
    @(negedge clk);
    n_chk++; if (a_if.cnv_cmplt !== 1'b0) begin n_err++; $display("FAIL single_one_pulse got %b exp 0", a_if.cnv_cmplt); end
    n_chk++; if (a_if.rd_res !== 12'hA5C) begin n_err++; $display("FAIL single_rd_res got %h exp a5c", a_if.rd_res); end
    n_chk++; if (a_if.vld !== 8'h20) begin n_err++; $display("FAIL single_vld got %h exp 20", a_if.vld); end
    n_chk++; if (slv[0].frm - f0 !== 2) begin n_err++; $display("FAIL single_frames got %0d exp 2", slv[0].frm - f0); end
    n_chk++; if (slv[0].lcmd !== 16'h2800) begin n_err++; $display("FAIL single_cmd got %h exp 2800", slv[0].lcmd); end
  endtask

  task automatic test_ignore_busy();
    int t, f0;
    for (int i = 0; i < 4; i++) tab[0][i] = 12'h3C1;
    f0 = slv[0].frm;
    a_if.rd_chnnl = 3'd0;
    a_if.scan_en = 1'b1;
    @(negedge clk);
    a_if.scan_en = 1'b0;
    a_if.chnnl = 3'd1; a_if.strt_cnv = 1'b1;
    @(negedge clk);
    a_if.strt_cnv = 1'b0;
    n_chk++; if (a_if.busy !== 1'b1) begin n_err++; $display("FAIL ign_busy got %b exp 1", a_if.busy); end
    t = 0;
    while (!a_if.cnv_cmplt && t < 3000) begin @(negedge clk); t++; end
    n_chk++; if (a_if.cmplt_chnnl !== 3'd0 || !a_if.cnv_cmplt) begin n_err++; $display("FAIL ign_cmplt_ch got %0d/%b exp 0/1", a_if.cmplt_chnnl, a_if.cnv_cmplt); end
    @(negedge clk);
    n_chk++; if (a_if.busy !== 1'b0) begin n_err++; $display("FAIL ign_idle got %b exp 0", a_if.busy); end
    n_chk++; if (a_if.vld !== 8'h21) begin n_err++; $display("FAIL ign_vld got %h exp 21", a_if.vld); end
    n_chk++; if (a_if.rd_res !== 12'h3C1) begin n_err++; $display("FAIL ign_rd_res got %h exp 3c1", a_if.rd_res); end
    repeat (50) @(negedge clk);
    n_chk++; if (slv[0].frm - f0 !== 2) begin n_err++; $display("FAIL ign_frames got %0d exp 2", slv[0].frm - f0); end
  endtask

  task automatic test_avg();
    int t;
    tab[1][0] = 12'h100; tab[1][1] = 12'h104; tab[1][2] = 12'h108; tab[1][3] = 12'h10C;
    b_if.rd_chnnl = 3'd2;
    b_if.chnnl = 3'd2; b_if.strt_cnv = 1'b1;
    @(negedge clk);
    b_if.strt_cnv = 1'b0;
    t = 0;
    while (!b_if.cnv_cmplt && t < 6000) begin @(negedge clk); t++; end
    n_chk++; if (b_if.cmplt_chnnl !== 3'd2 || !b_if.cnv_cmplt) begin n_err++; $display("FAIL avg_cmplt got %0d/%b exp 2/1", b_if.cmplt_chnnl, b_if.cnv_cmplt); end
    n_chk++; if (slv[1].frm !== 8) begin n_err++; $display("FAIL avg_frames got %0d exp 8", slv[1].frm); end
    @(negedge clk);
    n_chk++; if (b_if.rd_res !== 12'h106) begin n_err++; $display("FAIL avg_rd_res got %h exp 106", b_if.rd_res); end
    n_chk++; if (b_if.vld !== 4'b0100) begin n_err++; $display("FAIL avg_vld got %b exp 0100", b_if.vld); end
    n_chk++; if (slv[1].lcmd !== 16'h1000) begin n_err++; $display("FAIL avg_cmd got %h exp 1000", slv[1].lcmd); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] bad [2];
    int f0, act;
    bad[0] = 3'd7; bad[1] = 3'd4;
    for (int k = 0; k < 2; k++) begin
      f0 = slv[1].frm; act = 0;
      b_if.chnnl = bad[k]; b_if.strt_cnv = 1'b1;
      @(negedge clk);
      b_if.strt_cnv = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (b_if.busy || !ss_n[1]) act++;
        @(negedge clk);
      end
      n_chk++; if (act !== 0 || slv[1].frm !== f0) begin n_err++; $display("FAIL oor_ch%0d got act=%0d frames=%0d exp 0/%0d", bad[k], act, slv[1].frm, f0); end
    end
  endtask

  task automatic test_back_to_back_scan();
    logic [2:0] exp_ch [4];
    int t, gaps;
    exp_ch[0] = 3'd0; exp_ch[1] = 3'd1; exp_ch[2] = 3'd2; exp_ch[3] = 3'd0;
    for (int i = 0; i < 4; i++) tab[2][i] = 12'hFFF;
    gaps = 0;
    c_if.scan_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!c_if.cnv_cmplt && t < 3000) begin
        if (!c_if.busy) gaps++;
        @(negedge clk); t++;
      end
      n_chk++; if (c_if.cmplt_chnnl !== exp_ch[k] || !c_if.cnv_cmplt) begin n_err++; $display("FAIL scan_seq%0d got %0d/%b exp %0d/1", k, c_if.cmplt_chnnl, c_if.cnv_cmplt, exp_ch[k]); end
      if (k == 3) c_if.scan_en = 1'b0;
      @(negedge clk);
    end
    n_chk++; if (gaps !== 0) begin n_err++; $display("FAIL scan_gaps got %0d exp 0", gaps); end
    n_chk++; if (c_if.busy !== 1'b0) begin n_err++; $display("FAIL scan_stop got %b exp 0", c_if.busy); end
    n_chk++; if (c_if.vld !== 3'b111) begin n_err++; $display("FAIL scan_vld got %b exp 111", c_if.vld); end
    c_if.rd_chnnl = 3'd1; #1;
    n_chk++; if (c_if.rd_res !== 8'hFF) begin n_err++; $display("FAIL res8_rd_res got %h exp ff", c_if.rd_res); end
    c_if.rd_chnnl = 3'd3; #1;
    n_chk++; if (c_if.rd_res !== 8'h00) begin n_err++; $display("FAIL rd_oor got %h exp 00", c_if.rd_res); end
  endtask

  task automatic test_reset_mid();
    int t, f0, seen;
    for (int i = 0; i < 4; i++) tab[0][i] = 12'h777;
    f0 = slv[0].frm;
    a_if.chnnl = 3'd3; a_if.strt_cnv = 1'b1;
    @(negedge clk);
    a_if.strt_cnv = 1'b0;
    t = 0;
    while (slv[0].frm - f0 < 2 && t < 2000) begin @(negedge clk); t++; end
    repeat (100) @(negedge clk);
    n_chk++; if (ss_n[0] !== 1'b0) begin n_err++; $display("FAIL mid_in_frame got %b exp 0", ss_n[0]); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (a_if.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b exp 0", a_if.busy); end
    n_chk++; if (ss_n[0] !== 1'b1) begin n_err++; $display("FAIL mid_rst_ss_n got %b exp 1", ss_n[0]); end
    n_chk++; if (a_if.vld !== 8'h00) begin n_err++; $display("FAIL mid_rst_vld got %h exp 00", a_if.vld); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 1200; i++) begin
      if (a_if.cnv_cmplt || a_if.busy) seen++;
      @(negedge clk);
    end
    n_chk++; if (seen !== 0) begin n_err++; $display("FAIL mid_rst_quiet got %0d exp 0", seen); end
    a_if.rd_chnnl = 3'd5; #1;
    n_chk++; if (a_if.rd_res !== 12'h000) begin n_err++; $display("FAIL mid_rst_bank got %h exp 000", a_if.rd_res); end
  endtask

  initial begin
    rst = 1'b1;
    a_if.strt_cnv = 1'b0; a_if.chnnl = 3'd0; a_if.scan_en = 1'b0; a_if.rd_chnnl = 3'd0;
    b_if.strt_cnv = 1'b0; b_if.chnnl = 3'd0; b_if.scan_en = 1'b0; b_if.rd_chnnl = 3'd0;
    c_if.strt_cnv = 1'b0; c_if.chnnl = 3'd0; c_if.scan_en = 1'b0; c_if.rd_chnnl = 3'd0;
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 4; i++) tab[g][i] = 12'h000;
    test_reset();
    test_single();
    test_ignore_busy();
    test_avg();
    test_out_of_range();
    test_back_to_back_scan();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
